ram_access_scheduler: RTL
=========================

# ram_access_scheduler

Round-robin scheduler that shares one single-port 8-bit RAM among three processor requesters, one transaction at a time. It sits between the processor request ports and the RAM. It latches each granted request and sequences the RAM chip-select through a fixed number of wait states. It returns read data plus a one-cycle completion pulse to the owning requester. It replaces timeout-based bus ownership with per-transaction fairness.

## Interface
Parameters:
- ADDR_W, 12, address width
- DATA_W, 8, data width
- WAIT_STATES, 2, extra cycles chip-select is held beyond the first (0..15)
- RAM_DEPTH, 4096, number of valid RAM locations (used only with ADDR_GUARD_EN)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  3  request per requester; bit0=A, bit1=B, bit2=C; level, held until done
- r_wb  in  3  per-requester read(1)/write(0)
- addr  in  3*ADDR_W  packed addresses, A in LSBs
- wdata  in  3*DATA_W  packed write data, A in LSBs
- gnt  out  3  one-hot, one-cycle pulse: request latched
- done  out  3  one-hot, one-cycle pulse: transaction complete
- rdata  out  DATA_W  read data, valid in the done cycle
- err  out  1  valid in the done cycle; address rejected
- ram_cs  out  1  RAM chip-select
- ram_r_wb  out  1  RAM read(1)/write(0)
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; valid during the last cs cycle

## Operation
- All outputs are registered.
- Reset values:
  - gnt=0, done=0, rdata=0, err=0, ram_cs=0, ram_r_wb=1, ram_addr=0, ram_wdata=0.
  - State IDLE; round-robin pointer last=2, so A has first priority.
- States: IDLE, GRANT, ACCESS, COMPLETE.
- IDLE:
  - If any req bit is set, choose the winner by searching last+1, last+2, last+3 (mod 3).
  - Latch the winner's r_wb, addr and wdata; update last to the winner; go to GRANT.
  - If no req bit is set, stay in IDLE.
- GRANT:
  - gnt[winner]=1 for this cycle only.
  - Load the wait counter with WAIT_STATES; go to ACCESS.
- ACCESS:
  - ram_cs=1; ram_addr, ram_r_wb and ram_wdata are driven from the latches.
  - Counter decrements each cycle; at 0, go to COMPLETE.
  - ram_cs is high for exactly WAIT_STATES+1 cycles.
- COMPLETE:
  - ram_cs=0; done[winner]=1.
  - rdata holds ram_rdata sampled on the last ACCESS edge for reads; rdata=0 for writes.
  - Go to IDLE.
- Request handling:
  - Changes on req, r_wb, addr or wdata after the IDLE sampling edge are ignored.
  - If req drops mid-transaction, the transaction still completes and done still pulses.
  - A req still high in IDLE after its done is treated as a new transaction.
- Reset mid-operation:
  - ram_cs falls asynchronously; no done is issued.
  - The pointer returns to 2; the requester must re-request.
- ram_addr, ram_wdata and ram_r_wb hold their last values while ram_cs=0.

## Timing
- Edge E0 samples req in IDLE. Then:
  - cycle after E0: gnt
  - next WAIT_STATES+1 cycles: ram_cs
  - following cycle: done
  - next: IDLE
- Transaction length is WAIT_STATES+4 cycles, including IDLE.
- Back-to-back throughput is one transaction per WAIT_STATES+4 cycles.
- Simultaneous requests are served strictly in rotation. Worst-case wait for any requester is 2 transactions.

## Configuration
- ADDR_GUARD_EN defined:
  - The latched address is compared with RAM_DEPTH.
  - If addr >= RAM_DEPTH, GRANT goes directly to COMPLETE, ram_cs is never asserted, done pulses with err=1 and rdata=0.
  - Fairness pointer updates normally.
- ADDR_GUARD_EN undefined:
  - No check; all addresses are passed to the RAM.
  - err is tied 0; RAM_DEPTH is unused.

## Structure
- Package ram_sched_pkg holds:
  - state enum (IDLE, GRANT, ACCESS, COMPLETE)
  - NREQ=3
  - RD=1 / WR=0 encodings
  - requester index constants REQ_A=0, REQ_B=1, REQ_C=2
- Sub-module rr_pick3:
  - Combinational round-robin picker.
  - Inputs req[2:0] and last[1:0]; outputs one-hot sel[2:0], index win[1:0] and any.

## Test plan
- Single read: WAIT_STATES=2, A reads 0x123, RAM holds 0x5A -> gnt[0] in cycle 1, ram_cs cycles 2–4 with ram_addr=0x123 and ram_r_wb=1, done[0] in cycle 5 with rdata=0x5A.
- Contention: req=3'b111 held continuously from reset -> grant order A,B,C,A,B,C; exactly one gnt per 6 cycles.
- Write: C writes 0xC3 to 0x0FF -> ram_r_wb=0 and ram_wdata=0xC3 throughout ram_cs; done[2]; rdata=0.
- Reset mid-transaction: reset in the 2nd ram_cs cycle of a B read -> ram_cs=0 immediately, no done[1]; after release, req=3'b011 grants A first.
- Zero wait states: WAIT_STATES=0 -> ram_cs high exactly 1 cycle; done 2 cycles after gnt.
- Address guard: ADDR_GUARD_EN with RAM_DEPTH=2048, A reads 0x900 -> no ram_cs, done[0] with err=1 and rdata=0. Without the macro -> normal access, err=0.

Source files
------------

// File: rtl/ram_sched_pkg.sv
// rtl/ram_sched_pkg.sv - shared types and constants for the RAM access scheduler
package ram_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        ACCESS   = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    localparam int NREQ = 3;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational three-way round-robin picker
module rr_pick3
    import ram_sched_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] sel,
    output logic [1:0] win,
    output logic       any
);

    logic [1:0] idx;

    // Scan farthest-first so the requester nearest after last overwrites the rest
    always_comb begin
        idx = REQ_A;
        win = REQ_A;
        for (int k = NREQ; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % NREQ);
            if (req[idx]) begin
                win = idx;
            end
        end
        any = |req;
        sel = any ? (3'b001 << win) : 3'b000;
    end

endmodule

// File: rtl/ram_access_scheduler.sv
// rtl/ram_access_scheduler.sv - round-robin single-port RAM scheduler; ADDR_GUARD_EN enables the address range check
module ram_access_scheduler
    import ram_sched_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 2,
    parameter int RAM_DEPTH   = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [2:0]            r_wb,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            done,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err,
    output logic                  ram_cs,
    output logic                  ram_r_wb,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    state_t              state_q, state_d;
    logic [1:0]          last_q, last_d;
    logic [1:0]          win_q, win_d;
    logic                lat_rwb_q, lat_rwb_d;
    logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [2:0]          gnt_q, gnt_d;
    logic [2:0]          done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                cs_q, cs_d;
    logic                ram_r_wb_q, ram_r_wb_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

    logic [2:0]          pick_sel;
    logic [1:0]          pick_win;
    logic                pick_any;
    logic                guard_hit;

    rr_pick3 u_pick (
        .req  (req),
        .last (last_q),
        .sel  (pick_sel),
        .win  (pick_win),
        .any  (pick_any)
    );

`ifdef ADDR_GUARD_EN
    assign guard_hit = (int'(lat_addr_q) >= RAM_DEPTH);
`else
    assign guard_hit = 1'b0;
`endif

    // Transaction sequencer: latch winner, hold chip-select for the wait states, report completion
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        win_d       = win_q;
        lat_rwb_d   = lat_rwb_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        cnt_d       = cnt_q;
        gnt_d       = 3'b000;
        done_d      = 3'b000;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        cs_d        = cs_q;
        ram_r_wb_d  = ram_r_wb_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    win_d       = pick_win;
                    last_d      = pick_win;
                    lat_rwb_d   = r_wb[pick_win];
                    lat_addr_d  = addr[pick_win*ADDR_W +: ADDR_W];
                    lat_wdata_d = wdata[pick_win*DATA_W +: DATA_W];
                    gnt_d       = pick_sel;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                cnt_d = 4'(WAIT_STATES);
                if (guard_hit) begin
                    done_d  = 3'b001 << win_q;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = COMPLETE;
                end else begin
                    cs_d        = 1'b1;
                    ram_r_wb_d  = lat_rwb_q;
                    ram_addr_d  = lat_addr_q;
                    ram_wdata_d = lat_wdata_q;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    cs_d    = 1'b0;
                    done_d  = 3'b001 << win_q;
                    rdata_d = (lat_rwb_q == RD) ? ram_rdata : '0;
                    state_d = COMPLETE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            COMPLETE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops chip-select immediately and discards the transaction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= REQ_C;
            win_q       <= REQ_A;
            lat_rwb_q   <= RD;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            cnt_q       <= 4'd0;
            gnt_q       <= 3'b000;
            done_q      <= 3'b000;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cs_q        <= 1'b0;
            ram_r_wb_q  <= RD;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            lat_rwb_q   <= lat_rwb_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cs_q        <= cs_d;
            ram_r_wb_q  <= ram_r_wb_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign ram_cs    = cs_q;
    assign ram_r_wb  = ram_r_wb_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule
